// File: rtl/uart_pkg.sv
// uart_pkg: 16550 register map, LSR bits, init constants and driver FSM states
package uart_pkg;
  localparam logic [2:0] REG_THR = 3'd0;
  localparam logic [2:0] REG_RBR = 3'd0;
  localparam logic [2:0] REG_DLL = 3'd0;
  localparam logic [2:0] REG_IER = 3'd1;
  localparam logic [2:0] REG_DLM = 3'd1;
  localparam logic [2:0] REG_FCR = 3'd2;
  localparam logic [2:0] REG_IIR = 3'd2;
  localparam logic [2:0] REG_LCR = 3'd3;
  localparam logic [2:0] REG_MCR = 3'd4;
  localparam logic [2:0] REG_LSR = 3'd5;
  localparam logic [2:0] REG_MSR = 3'd6;
  localparam logic [2:0] REG_SCR = 3'd7;
  localparam int LSR_THRE = 5;
  localparam int LSR_TEMT = 6;
  localparam logic [7:0] LCR_DLAB = 8'h80;
  localparam logic [7:0] LCR_8N1  = 8'h03;
  localparam logic [7:0] FCR_INIT = 8'h07;
  localparam logic [7:0] IER_INIT = 8'h00;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_POLL, ST_TX} state_e;
  // {register index, value} for each programming step
  function automatic logic [10:0] init_step(input logic [2:0] s, input logic [15:0] div);
    return s == 3'd0 ? {REG_LCR, LCR_DLAB} :
           s == 3'd1 ? {REG_DLL, div[7:0]} :
           s == 3'd2 ? {REG_DLM, div[15:8]} :
           s == 3'd3 ? {REG_LCR, LCR_8N1} :
           s == 3'd4 ? {REG_FCR, FCR_INIT} : {REG_IER, IER_INIT};
  endfunction
endpackage

// File: rtl/apb_uart_xfer.sv
// apb_uart_xfer: single APB transfer engine; SETUP then ACCESS held until pready
module apb_uart_xfer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);
  logic        psel_q, penable_q, pwrite_q;
  logic [31:0] paddr_q, pwdata_q;
  assign done_o    = penable_q & pready_i;
  assign err_o     = done_o & pslverr_i;
  assign rdata_o   = prdata_i;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;
  // a request is only taken while deselected, which forces the idle gap after each completion
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
    end else if (!psel_q) begin
      psel_q <= req_i;
      if (req_i) begin
        paddr_q  <= addr_i;
        pwdata_q <= wdata_i;
        pwrite_q <= write_i;
      end
    end else begin
      penable_q <= !done_o;
      psel_q    <= !done_o;
    end
  end
endmodule

// File: rtl/apb_uart_tx_driver.sv
// apb_uart_tx_driver: programs a 16550 UART over APB, then streams FIFO-buffered bytes to THR
// APB_UART_LSR_POLL_EN: read LSR and require THRE before every THR write
module apb_uart_tx_driver
  import uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  parameter logic [15:0] DIVISOR    = 16'd1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        init_done_o,
  output logic        busy_o,
  output logic        err_o,
  output logic [31:0] paddr_o,
  output logic        psel_o,
  output logic        penable_o,
  output logic        pwrite_o,
  output logic [31:0] pwdata_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  state_e        state_q;
  logic [2:0]    step_q;
  logic          init_done_q, err_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic          push_w, pop_w, empty_w, req_w, write_w, done_w, xerr_w, unused_w;
  logic [2:0]    idx_w;
  logic [7:0]    byte_w;
  logic [10:0]   init_w;
  logic [31:0]   rdata_w;
  assign empty_w     = cnt_q == '0;
  assign ready_o     = init_done_q & (cnt_q != FULL);
  assign push_w      = valid_i & ready_o;
  assign pop_w       = state_q == ST_TX & done_w;
  assign busy_o      = !empty_w | psel_o;
  assign init_done_o = init_done_q;
  assign err_o       = err_q;
  assign init_w      = init_step(step_q, DIVISOR);
  assign req_w       = state_q == ST_IDLE ? !empty_w | push_w : 1'b1;
  // an empty FIFO forwards the byte being pushed so THR SETUP follows the push directly
  assign byte_w      = state_q == ST_INIT ? init_w[7:0] : empty_w ? data_i : mem_q[rp_q];
  assign unused_w    = ^rdata_w;
`ifdef APB_UART_LSR_POLL_EN
  assign idx_w   = state_q == ST_INIT ? init_w[10:8] : state_q == ST_IDLE ? REG_LSR : REG_THR;
  assign write_w = state_q != ST_IDLE;
`else
  assign idx_w   = state_q == ST_INIT ? init_w[10:8] : REG_THR;
  assign write_w = 1'b1;
`endif
  apb_uart_xfer u_xfer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_w),
    .write_i   (write_w),
    .addr_i    (BASE_ADDR + {27'd0, idx_w, 2'b00}),
    .wdata_i   ({24'd0, byte_w}),
    .done_o    (done_w),
    .err_o     (xerr_w),
    .rdata_o   (rdata_w),
    .paddr_o   (paddr_o),
    .psel_o    (psel_o),
    .penable_o (penable_o),
    .pwrite_o  (pwrite_o),
    .pwdata_o  (pwdata_o),
    .prdata_i  (prdata_i),
    .pready_i  (pready_i),
    .pslverr_i (pslverr_i)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      step_q      <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= err_q | xerr_w;
      case (state_q)
        ST_INIT: if (done_w) begin
          step_q <= step_q + 3'd1;
          if (step_q == 3'd5) begin
            state_q     <= ST_IDLE;
            init_done_q <= 1'b1;
          end
        end
`ifdef APB_UART_LSR_POLL_EN
        ST_IDLE: if (req_w) state_q <= ST_POLL;
        ST_POLL: if (done_w) state_q <= rdata_w[LSR_THRE] & !xerr_w ? ST_TX : ST_IDLE;
`else
        ST_IDLE: if (req_w) state_q <= ST_TX;
`endif
        ST_TX: if (done_w) state_q <= ST_IDLE;
        default: state_q <= ST_INIT;
      endcase
    end
  end
  always_ff @(posedge clk_i) if (push_w) mem_q[wp_q] <= data_i;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push_w);
      rp_q  <= rp_q + AW'(pop_w);
      cnt_q <= cnt_q + CW'(push_w) - CW'(pop_w);
    end
  end
endmodule

// File: tb/tb_apb_uart_tx_driver.sv
// tb_apb_uart_tx_driver: mock APB UART with write log, byte-stream scoreboard and protocol monitor
`timescale 1ns/1ps
module tb_apb_uart_tx_driver;
  localparam logic [31:0] BASE  = 32'h4000_1000;
  localparam logic [15:0] DIV   = 16'h1201;
  localparam int          DEPTH = 4;
  typedef struct {logic [31:0] addr; logic [31:0] data;} wr_t;
  logic        clk = 1'b0, rst = 1'b1;
  logic [7:0]  data_i = 8'h0;
  logic        valid_i = 1'b0;
  logic        ready_o, init_done_o, busy_o, err_o, psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata;
  logic        pready_r = 1'b1, pslverr_r = 1'b0, pready_w, compl;
  int          n_chk = 0, n_fail = 0, n_lsr_rd = 0, lsr_until = 0;
  wr_t         log_q[$];
  logic [7:0]  exp_q[$];
  logic        pv_sel = 1'b0, pv_done = 1'b0;
  logic [31:0] pv_addr = '0, pv_data = '0;

  always #5 clk = ~clk;
  // reads always complete at once; stalls and errors apply to writes only
  assign pready_w = pready_r | !pwrite_o;
  assign compl    = psel_o & penable_o & pready_w;
  assign prdata   = n_lsr_rd < lsr_until ? 32'h0 : 32'h20;

  apb_uart_tx_driver #(.BASE_ADDR(BASE), .DIVISOR(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .init_done_o(init_done_o), .busy_o(busy_o), .err_o(err_o), .paddr_o(paddr_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata), .pready_i(pready_w), .pslverr_i(pslverr_r & pwrite_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) if (compl & !pwrite_o) n_lsr_rd <= n_lsr_rd + 1;

  always @(negedge clk) begin
    if (rst) begin
      pv_sel  <= 1'b0;
      pv_done <= 1'b0;
    end else begin
      if (pv_done) chk("idle_gap", {31'd0, psel_o}, 32'd1 - 32'd1);
      else if (pv_sel) begin
        chk("hold_sel", {31'd0, psel_o}, 32'd1);
        chk("hold_en", {31'd0, penable_o}, 32'd1);
        chk("hold_addr", paddr_o, pv_addr);
        chk("hold_data", pwdata_o, pv_data);
      end
      if (compl & pwrite_o) log_q.push_back('{paddr_o, pwdata_o});
      if (compl & !pwrite_o) chk("lsr_addr", paddr_o, BASE + 32'h14);
      pv_sel  <= psel_o;
      pv_done <= compl;
      pv_addr <= paddr_o;
      pv_data <= pwdata_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int n = 0;
    valid_i = 1'b1;
    data_i  = b;
    @(negedge clk);
    while (!ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", {31'd0, ready_o}, 32'd1);
    exp_q.push_back(b);
    tick();
  endtask

  task automatic wait_init();
    int n = 0;
    @(negedge clk);
    while (!init_done_o && n < 200) begin
      chk("ready_in_init", {31'd0, ready_o}, 32'd0);
      @(negedge clk);
      n++;
    end
    chk("init_done", {31'd0, init_done_o}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", {31'd0, busy_o}, 32'd0);
  endtask

  task automatic wait_acc();
    int n = 0;
    @(negedge clk);
    while (!(psel_o & penable_o & pwrite_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("write_access", {31'd0, psel_o & penable_o & pwrite_o}, 32'd1);
  endtask

  task automatic check_init();
    wr_t t[6];
    t[0] = '{BASE + 32'hC, 32'h80};
    t[1] = '{BASE,         {24'd0, DIV[7:0]}};
    t[2] = '{BASE + 32'h4, {24'd0, DIV[15:8]}};
    t[3] = '{BASE + 32'hC, 32'h03};
    t[4] = '{BASE + 32'h8, 32'h07};
    t[5] = '{BASE + 32'h4, 32'h00};
    chk("init_len", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++) begin
      chk("init_addr", log_q[i].addr, t[i].addr);
      chk("init_data", log_q[i].data, t[i].data);
    end
  endtask

  task automatic check_log(input string nm);
    chk({nm, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
      chk({nm, "_addr"}, log_q[i].addr, BASE);
      chk({nm, "_data"}, log_q[i].data, {24'd0, exp_q[i]});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    int n, g, stop;
    // reset state
    repeat (2) @(negedge clk);
    chk("rst_psel", {31'd0, psel_o}, 32'd0);
    chk("rst_penable", {31'd0, penable_o}, 32'd0);
    chk("rst_pwrite", {31'd0, pwrite_o}, 32'd0);
    chk("rst_paddr", paddr_o, 32'd0);
    chk("rst_pwdata", pwdata_o, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd0);
    chk("rst_init_done", {31'd0, init_done_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    tick();
    rst = 1'b0;
    wait_init();
    check_init();
    chk("ready_after_init", {31'd0, ready_o}, 32'd1);
    chk("busy_after_init", {31'd0, busy_o}, 32'd0);

    // 'H','i' back-to-back with SETUP/ACCESS timing after the first push
    log_q.delete();
    exp_q.delete();
    tick();
    valid_i = 1'b1;
    data_i  = 8'h48;
    @(negedge clk);
    chk("h_ready", {31'd0, ready_o}, 32'd1);
    exp_q.push_back(8'h48);
    tick();
    data_i = 8'h69;
    @(negedge clk);
    chk("setup_sel", {31'd0, psel_o}, 32'd1);
    chk("setup_en", {31'd0, penable_o}, 32'd0);
`ifdef APB_UART_LSR_POLL_EN
    chk("setup_addr", paddr_o, BASE + 32'h14);
`else
    chk("setup_addr", paddr_o, BASE);
    chk("setup_data", pwdata_o, 32'h48);
`endif
    chk("i_ready", {31'd0, ready_o}, 32'd1);
    exp_q.push_back(8'h69);
    tick();
    valid_i = 1'b0;
    @(negedge clk);
    chk("access_en", {31'd0, penable_o}, 32'd1);
    wait_idle();
    check_log("hi");
    chk("err_clean", {31'd0, err_o}, 32'd0);

    // ACCESS stretched by three pready=0 cycles
    log_q.delete();
    exp_q.delete();
    tick();
    pready_r = 1'b0;
    push(8'h5A);
    valid_i = 1'b0;
    wait_acc();
    a = paddr_o;
    d = pwdata_o;
    chk("stall_addr", a, BASE);
    chk("stall_data", d, 32'h5A);
    for (int k = 0; k < 3; k++) begin
      chk("stall_sel", {31'd0, psel_o}, 32'd1);
      chk("stall_en", {31'd0, penable_o}, 32'd1);
      chk("stall_paddr", paddr_o, a);
      chk("stall_pwdata", pwdata_o, d);
      chk("stall_nolog", log_q.size(), 0);
      if (k < 2) @(negedge clk);
    end
    tick();
    pready_r = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_released", {31'd0, psel_o}, 32'd0);
    check_log("stall");

    // overflow: DEPTH bytes fill the FIFO behind a stalled write, one more after release
    log_q.delete();
    exp_q.delete();
    tick();
    pready_r = 1'b0;
    for (int i = 0; i < DEPTH; i++) push(8'hA0 + 8'(i));
    valid_i = 1'b0;
    @(negedge clk);
    chk("full_ready", {31'd0, ready_o}, 32'd0);
    @(negedge clk);
    chk("full_ready_hold", {31'd0, ready_o}, 32'd0);
    tick();
    pready_r = 1'b1;
    push(8'hA0 + 8'(DEPTH));
    valid_i = 1'b0;
    wait_idle();
    check_log("overflow");

    // slave error on a THR write: sticky err, next byte still sent
    log_q.delete();
    exp_q.delete();
    tick();
    pslverr_r = 1'b1;
    push(8'h11);
    valid_i = 1'b0;
    n = 0;
    while (log_q.size() == 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("err_write_seen", log_q.size(), 1);
    tick();
    pslverr_r = 1'b0;
    chk("err_set", {31'd0, err_o}, 32'd1);
    push(8'h22);
    valid_i = 1'b0;
    wait_idle();
    check_log("slverr");
    chk("err_sticky", {31'd0, err_o}, 32'd1);

    // reset asserted in the middle of an ACCESS
    tick();
    pready_r = 1'b0;
    push(8'h33);
    valid_i = 1'b0;
    wait_acc();
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_psel", {31'd0, psel_o}, 32'd0);
    chk("mid_rst_penable", {31'd0, penable_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_ready", {31'd0, ready_o}, 32'd0);
    chk("mid_rst_init", {31'd0, init_done_o}, 32'd0);
    chk("mid_rst_err", {31'd0, err_o}, 32'd0);
    tick();
    pready_r = 1'b1;
    log_q.delete();
    tick();
    rst = 1'b0;
    wait_init();
    check_init();
    chk("reinit_busy", {31'd0, busy_o}, 32'd0);

    // LSR polling
    log_q.delete();
    exp_q.delete();
`ifdef APB_UART_LSR_POLL_EN
    tick();
    n = n_lsr_rd;
    lsr_until = n_lsr_rd + 2;
    push(8'h7E);
    valid_i = 1'b0;
    wait_idle();
    chk("lsr_reads", n_lsr_rd - n, 3);
    check_log("poll");
`else
    chk("no_lsr_reads", n_lsr_rd, 0);
`endif

    // random byte stream with random write stalls against the in-order byte model
    log_q.delete();
    exp_q.delete();
    stop = 0;
    tick();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          g = $urandom_range(0, 2);
          if (g != 0) begin
            valid_i = 1'b0;
            repeat (g) tick();
          end
          push(8'($urandom));
        end
        valid_i = 1'b0;
        stop = 1;
      end
      begin
        while (stop == 0) begin
          tick();
          pready_r = $urandom_range(0, 3) != 0;
        end
        pready_r = 1'b1;
      end
    join
    wait_idle();
    check_log("random");
    chk("random_err", {31'd0, err_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
